// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int INSTR_W  = 32;
    localparam int PC_INCR  = 4;
    localparam int BR_SHIFT = 2;

endpackage

// File: rtl/branch_target.sv
// Branch target adder: pc plus a word offset scaled to bytes, modulo 2^N.
module branch_target
    import fetch_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [N-1:0] pc,
    input  logic [N-1:0] sign_imm,
    output logic [N-1:0] target
);

    // Shifting at width N drops the top BR_SHIFT bits of the offset.
    assign target = pc + (sign_imm << BR_SHIFT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction
// over req/ack and buffers it for decode until consumed.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [N-1:0]       pc,
    input  logic               pc_src,
    input  logic [N-1:0]       sign_imm
);

    // state | meaning
    // IDLE  | one settling cycle after reset, no request
    // REQ   | imem_req high at pc, waiting for imem_ack
    // HOLD  | instr valid, waiting for decode to consume it
    fetch_state_t state;

    logic [N-1:0] pc_plus4;
    logic [N-1:0] pc_branch;

    assign pc_plus4  = pc + N'(PC_INCR);
    assign imem_addr = pc;

    branch_target #(.N(N)) u_branch_target (
        .pc       (pc),
        .sign_imm (sign_imm),
        .target   (pc_branch)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= HOLD;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    // Branch inputs only matter on the consuming edge.
                    if (instr_valid && instr_ready) begin
                        pc          <= pc_src ? pc_branch : pc_plus4;
                        state       <= REQ;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule
